psum_drain: RTL and testbench
=============================

Name: psum_drain

Overview:
- Output-side reader for the N×N systolic MAC array. It is the consumer of the psum values the process elements produce.
- After the array controller signals that the final operand pair has entered PE(0,0), the block waits a fixed settle time for the skewed wavefront to finish accumulating in PE(N-1,N-1).
- It then snapshots every PE psum in a single cycle, pulses a clear to the array, and streams the result matrix out one row per valid/ready handshake.
- It sits between the PE grid and the result write-back path.

Parameters:
- N, 4: array dimension (rows = columns); must be ≥ 2.
- DW, 16: psum width; equals `DATA_WIDTH; signed Q8.8.
- SETTLE, 2*N: number of cycles from the done_i sample edge to the capture edge; must be ≥ 1.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous, active-low reset.
- done_i  in  1  one-cycle pulse; the last operand pair enters PE(0,0) on this edge.
- psum_i  in  N*N*DW  flattened PE outputs; PE(r,c) is at bits [(r*N+c)*DW +: DW].
- clear_o  out  1  accumulator clear pulse to the array, driven into PE(0,0).
- busy_o  out  1  high whenever state ≠ IDLE.
- out_valid_o  out  1  row data valid.
- out_ready_i  in  1  downstream accept.
- out_data_o  out  N*DW  current row; column c is at bits [c*DW +: DW].
- out_row_o  out  clog2(N)  index of the current row.
- out_last_o  out  1  high with valid when out_row_o == N-1.
- err_o  out  1  sticky: done_i arrived while busy.

Behaviour:
- Reset (async assert, any state): state=IDLE, settle counter=0, row=0, snapshot buffer=0. All outputs are 0: clear_o, busy_o, out_valid_o, out_data_o, out_row_o, out_last_o, err_o.
- State IDLE:
  - done_i=1 at edge E0 → state WAIT, counter=1.
  - Otherwise remain in IDLE.
- State WAIT:
  - At each edge, counter increments.
  - At edge E0+SETTLE, all N*N psum_i words are registered into the snapshot buffer, state becomes DRAIN, and row becomes 0.
  - If SETTLE==1, capture happens at edge E0+1.
- clear_o: registered. It is high for exactly the one cycle following the capture edge and low at all other times.
- State DRAIN:
  - out_valid_o=1.
  - out_data_o = buffer row `row`, driven from registers with no combinational path from psum_i.
  - out_row_o=row; out_last_o=(row==N-1).
  - An edge with out_valid_o & out_ready_i is a transfer:
    - If row<N-1: row increments.
    - If row==N-1: state=IDLE, out_valid_o=0, row=0.
  - With out_ready_i low, out_data_o, out_row_o and out_valid_o are held stable.
  - Minimum drain time is N cycles with ready tied high.
- busy_o = (state≠IDLE). It is registered via the state encoding.
- done_i while state≠IDLE: ignored for sequencing, and err_o is set to 1 at that edge. err_o stays set until reset. done_i in the same cycle as the final-row transfer is also a busy-state arrival: it sets err_o and is ignored.
- Arithmetic: no arithmetic on data. Words pass bit-exact; the snapshot is a plain copy with no rounding or saturation.
- Latency: done_i edge → first out_valid_o high = SETTLE cycles. out_valid_o is first observable in the cycle after edge E0+SETTLE.
- Buffer contents persist after returning to IDLE. out_data_o in IDLE shows row 0 of the last snapshot; consumers must qualify with valid.

Test Plan:
- Basic drain: N=4, SETTLE=8, psum_i[PE(r,c)]=16'h0100*(r*4+c+1).
  - Pulse done_i at edge 10, ready=1.
  - Required: capture at edge 18; clear_o high for 1 cycle after edge 18.
  - Rows 0..3 transfer on edges 19–22, row 2 data = {0C00,0B00,0A00,0900} (c3..c0).
  - out_last_o only with row 3; busy_o drops after edge 22.
- Capture isolation: after the capture edge, change psum_i to all 16'hFFFF. Required: the drained data still equals the captured values.
- Backpressure: ready low for 5 cycles on row 1, then high. Required: row 1 data and out_row_o stable throughout; rows emitted in order 0,1,2,3 with no duplicates or skips.
- Overrun:
  - Pulse done_i during WAIT → err_o=1 from the next cycle; sequence timing unchanged.
  - Pulse done_i in the final-row transfer cycle → err_o=1; no new capture.
  - A done_i one cycle after returning to IDLE starts a new capture normally.
- Reset mid-DRAIN: assert rst_ni low while row=2. Required: all outputs are 0 immediately (async), and the block does not resume after release. A fresh done_i then yields a full 4-row drain.
- SETTLE=1: done_i at edge E → capture at edge E+1, valid in the following cycle, clear_o pulse coincides with the first valid cycle.

Source files
------------

// File: rtl/psum_drain.sv
// Snapshots all N*N PE psums SETTLE cycles after done_i, pulses clear_o, then drains one row per handshake.
// Latency done_i->out_valid_o is SETTLE cycles; out_ready_i low holds the presented row and index stable.
module psum_drain #(
  parameter int N      = 4,
  parameter int DW     = 16,
  parameter int SETTLE = 2*N
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   done_i,
  input  logic [N*N*DW-1:0]      psum_i,
  output logic                   clear_o,
  output logic                   busy_o,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [N*DW-1:0]        out_data_o,
  output logic [$clog2(N)-1:0]   out_row_o,
  output logic                   out_last_o,
  output logic                   err_o
);

  localparam int RW = $clog2(N);
  localparam int CW = $clog2(SETTLE + 1);

  // bit0 = busy, bit1 = valid, so both outputs come straight from the state flops
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    WAIT  = 2'b01,
    DRAIN = 2'b11
  } state_t;

  state_t                   state_q, state_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [RW-1:0]            row_q, row_d;
  logic [N-1:0][N*DW-1:0]   buf_q;
  logic                     capture;
  logic                     last_row;
  logic                     clear_q;
  logic                     err_q;

  assign last_row = (row_q == RW'(N - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    row_d   = row_q;
    capture = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (done_i) begin
          state_d = WAIT;
          cnt_d   = CW'(1);
        end
      end
      WAIT: begin
        if (cnt_q == CW'(SETTLE)) begin
          capture = 1'b1;
          state_d = DRAIN;
          row_d   = '0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DRAIN: begin
        if (out_ready_i) begin
          if (last_row) begin
            state_d = IDLE;
            row_d   = '0;
          end else begin
            row_d = row_q + RW'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        row_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      row_q   <= '0;
      clear_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      row_q   <= row_d;
      clear_q <= capture;
      // a done_i that lands on the final-row transfer still counts as an overrun
      err_q   <= err_q | (done_i & (state_q != IDLE));
    end
  end

  // Row r of psum_i is already contiguous with column c at c*DW, so a flat copy suffices
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      buf_q <= '0;
    end else if (capture) begin
      buf_q <= psum_i;
    end
  end

  assign busy_o      = state_q[0];
  assign out_valid_o = state_q[1];
  assign out_data_o  = buf_q[row_q];
  assign out_row_o   = row_q;
  assign out_last_o  = state_q[1] & last_row;
  assign clear_o     = clear_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_psum_drain.sv
// Scoreboard bench for psum_drain: a time-based reference model queues captured rows, a monitor checks every cycle.
module tb_psum_drain;

  localparam int N      = 4;
  localparam int DW     = 16;
  localparam int SETTLE = 2*N;
  localparam int RW     = $clog2(N);
  localparam int PW     = N*N*DW;
  localparam int OW     = N*DW;

  logic            clk = 1'b0;
  logic            rst_ni = 1'b1;
  logic            done_i = 1'b0;
  logic            out_ready_i = 1'b1;
  logic [PW-1:0]   psum_i = '0;
  logic            clear_o, busy_o, out_valid_o, out_last_o, err_o;
  logic [OW-1:0]   out_data_o;
  logic [RW-1:0]   out_row_o;

  logic            done1 = 1'b0;
  logic            u1_clear, u1_busy, u1_valid, u1_last, u1_err;
  logic [OW-1:0]   u1_data;
  logic [RW-1:0]   u1_row;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  psum_drain #(.N(N), .DW(DW), .SETTLE(SETTLE)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .done_i(done_i), .psum_i(psum_i),
    .clear_o(clear_o), .busy_o(busy_o), .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i), .out_data_o(out_data_o), .out_row_o(out_row_o),
    .out_last_o(out_last_o), .err_o(err_o)
  );

  psum_drain #(.N(N), .DW(DW), .SETTLE(1)) dut_s1 (
    .clk_i(clk), .rst_ni(rst_ni), .done_i(done1), .psum_i(psum_i),
    .clear_o(u1_clear), .busy_o(u1_busy), .out_valid_o(u1_valid),
    .out_ready_i(1'b1), .out_data_o(u1_data), .out_row_o(u1_row),
    .out_last_o(u1_last), .err_o(u1_err)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 idle, 1 waiting for capture time, 2 draining.
  typedef struct {
    int            row;
    logic [OW-1:0] data;
  } exp_t;
  exp_t          expq[$];
  int            m_phase = 0;
  int            cyc = 0;
  int            cap_cyc = 0;
  int            rows_left = 0;
  logic          m_clear = 1'b0;
  logic          m_err = 1'b0;
  logic [OW-1:0] m_row0 = '0;

  initial begin
    forever begin
      @(posedge clk or negedge rst_ni);
      if (!rst_ni) begin
        m_phase = 0; m_clear = 1'b0; m_err = 1'b0; m_row0 = '0; rows_left = 0;
        expq.delete();
      end else begin
        int p;
        p = m_phase;
        cyc++;
        m_clear = 1'b0;
        if (done_i && p != 0) m_err = 1'b1;
        if (p == 0 && done_i) begin
          m_phase = 1;
          cap_cyc = cyc + SETTLE;
        end else if (p == 1 && cyc == cap_cyc) begin
          for (int r = 0; r < N; r++) begin
            exp_t e;
            e.row  = r;
            e.data = psum_i[r*OW +: OW];
            expq.push_back(e);
          end
          m_row0    = psum_i[OW-1:0];
          m_phase   = 2;
          rows_left = N;
          m_clear   = 1'b1;
        end else if (p == 2 && out_ready_i) begin
          rows_left--;
          if (rows_left == 0) m_phase = 0;
        end
      end
    end
  end

  // Monitor: compares every cycle on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      chk("busy", 64'(busy_o), 64'(m_phase != 0));
      chk("valid", 64'(out_valid_o), 64'(m_phase == 2));
      chk("clear", 64'(clear_o), 64'(m_clear));
      chk("err", 64'(err_o), 64'(m_err));
      if (m_phase == 2) begin
        if (expq.size() == 0) begin
          checks++; errors++;
          $display("FAIL scoreboard_empty: valid row with nothing expected (t=%0t)", $time);
        end else begin
          chk("row_idx", 64'(out_row_o), 64'(expq[0].row));
          chk("row_data", 64'(out_data_o), 64'(expq[0].data));
          chk("row_last", 64'(out_last_o), 64'(expq[0].row == N - 1));
          if (out_ready_i) void'(expq.pop_front());
        end
      end else begin
        chk("idle_row", 64'(out_row_o), 64'd0);
        chk("idle_last", 64'(out_last_o), 64'd0);
        chk("idle_data", 64'(out_data_o), 64'(m_row0));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse_done();
    tick(); done_i = 1'b1;
    tick(); done_i = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (m_phase != 0 && n < 400) begin
      tick();
      n++;
    end
    if (m_phase != 0) begin
      checks++; errors++;
      $display("FAIL wait_idle: drain still running after %0d cycles", n);
    end
  endtask

  task automatic rand_psum();
    for (int i = 0; i < PW/32; i++) psum_i[i*32 +: 32] = $urandom;
  endtask

  initial begin
    #1 rst_ni = 1'b0;
    #3;
    chk("rst_valid", 64'(out_valid_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    repeat (3) tick();
    rst_ni = 1'b1;
    repeat (2) tick();

    // Basic drain with the ramp pattern, then capture isolation
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        psum_i[(r*N + c)*DW +: DW] = DW'(16'h0100 * (r*N + c + 1));
    pulse_done();
    repeat (SETTLE) tick();
    chk("plan_clear", 64'(clear_o), 64'd1);
    chk("plan_first_valid", 64'(out_valid_o), 64'd1);
    psum_i = '1;
    tick();
    tick();
    chk("plan_row2", 64'(out_data_o), 64'h0C00_0B00_0A00_0900);
    tick();
    chk("plan_last", 64'(out_last_o), 64'd1);
    wait_idle();

    // Backpressure on row 1
    rand_psum();
    pulse_done();
    repeat (SETTLE) tick();
    tick();
    out_ready_i = 1'b0;
    repeat (5) tick();
    out_ready_i = 1'b1;
    wait_idle();

    // Overrun during WAIT
    pulse_done();
    repeat (3) tick();
    done_i = 1'b1;
    tick();
    done_i = 1'b0;
    chk("overrun_wait_err", 64'(err_o), 64'd1);
    wait_idle();

    // Reset while row 2 is presented
    rand_psum();
    pulse_done();
    repeat (SETTLE) tick();
    tick();
    tick();
    out_ready_i = 1'b0;
    chk("pre_rst_row", 64'(out_row_o), 64'd2);
    #1 rst_ni = 1'b0;
    #1;
    chk("async_valid", 64'(out_valid_o), 64'd0);
    chk("async_busy", 64'(busy_o), 64'd0);
    chk("async_data", 64'(out_data_o), 64'd0);
    chk("async_row", 64'(out_row_o), 64'd0);
    chk("async_err", 64'(err_o), 64'd0);
    chk("async_last", 64'(out_last_o), 64'd0);
    repeat (2) tick();
    rst_ni = 1'b1;
    out_ready_i = 1'b1;
    repeat (3) tick();
    pulse_done();
    wait_idle();

    // done_i on the final-row transfer edge, then a normal restart
    rand_psum();
    pulse_done();
    repeat (SETTLE + 3) tick();
    done_i = 1'b1;
    tick();
    done_i = 1'b0;
    chk("final_xfer_err", 64'(err_o), 64'd1);
    chk("final_xfer_idle", 64'(busy_o), 64'd0);
    rand_psum();
    pulse_done();
    wait_idle();

    // Random traffic: stray done pulses, random ready, psum changing every cycle
    repeat (600) begin
      tick();
      done_i      = ($urandom_range(19) == 0);
      out_ready_i = ($urandom_range(3) != 0);
      rand_psum();
    end
    done_i = 1'b0;
    out_ready_i = 1'b1;
    wait_idle();
    chk("scoreboard_drained", 64'(expq.size()), 64'd0);

    // SETTLE=1 instance: capture one edge after done, clear coincides with first valid
    rand_psum();
    tick(); done1 = 1'b1;
    tick(); done1 = 1'b0;
    chk("s1_wait_busy", 64'(u1_busy), 64'd1);
    chk("s1_wait_valid", 64'(u1_valid), 64'd0);
    tick();
    chk("s1_clear", 64'(u1_clear), 64'd1);
    for (int r = 0; r < N; r++) begin
      chk("s1_valid", 64'(u1_valid), 64'd1);
      chk("s1_row", 64'(u1_row), 64'(r));
      chk("s1_data", 64'(u1_data), 64'(psum_i[r*OW +: OW]));
      chk("s1_last", 64'(u1_last), 64'(r == N - 1));
      if (r > 0) chk("s1_clear_low", 64'(u1_clear), 64'd0);
      tick();
    end
    chk("s1_done_valid", 64'(u1_valid), 64'd0);
    chk("s1_done_busy", 64'(u1_busy), 64'd0);
    chk("s1_err", 64'(u1_err), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
